// File: rtl/uart_tx.sv
// uart_tx: FSM-based UART transmitter with a one-entry holding register.
//
// Each byte goes out as 8N1: one start bit (0), eight data bits LSB first,
// one stop bit (1). Every bit lasts CLKS_PER_BIT clock cycles. The holding
// register can take the next byte while a frame is on the line, so frames
// can follow each other with no idle gap.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (8E1 framing, 11 bit periods).
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset; aborts any frame in progress
//   tx_start  byte-valid strobe, accepted when tx_start && tx_ready
//   tx_data   byte to send, sampled only on the accept edge
//   tx        serial line, registered, idles high
//   tx_ready  holding register empty
//   tx_busy   a frame is on the line
//   tx_done   one-cycle pulse after the last stop-bit cycle

module uart_tx #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StStop   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] StParity = 3'd4;
`endif

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_valid_q, hold_valid_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            bit_end;

  assign bit_end = (clk_cnt_q == CntLast);

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    tx_d         = tx_q;
    done_d       = 1'b0;

    // Accept needs an empty holding register and the transfer below needs a
    // full one, so the two never collide on the same edge.
    if (tx_start && !hold_valid_q) begin
      hold_d       = tx_data;
      hold_valid_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        tx_d      = 1'b1;
        clk_cnt_d = '0;
        if (hold_valid_q) begin
          state_d      = StStart;
          tx_d         = 1'b0;
          shift_d      = hold_q;
          hold_valid_d = 1'b0;
          bit_idx_d    = 3'd0;
        end
      end

      StStart: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = 3'd0;
          state_d   = StData;
          tx_d      = shift_q[0];
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end

      StData: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            tx_d    = ^shift_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[bit_idx_q + 3'd1];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          state_d   = StStop;
          tx_d      = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end
`endif

      StStop: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          done_d    = 1'b1;
          if (hold_valid_q) begin
            // Chain straight into the next frame: no idle cycle.
            state_d      = StStart;
            tx_d         = 1'b0;
            shift_d      = hold_q;
            hold_valid_d = 1'b0;
            bit_idx_d    = 3'd0;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end

      default: begin
        state_d   = StIdle;
        clk_cnt_d = '0;
        tx_d      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      clk_cnt_q    <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'd0;
      hold_q       <= 8'd0;
      hold_valid_q <= 1'b0;
      tx_q         <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      tx_q         <= tx_d;
      done_q       <= done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign tx_ready = !hold_valid_q;
  assign tx_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx.
// Two instances (16 and 2 clocks per bit) are checked every cycle against a
// timestamp-based frame model, plus directed scenarios with literal
// expectations on the received bits and frame timing.

module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME16 = NB * 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b1, rst1 = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [7:0] data0 = 8'd0, data1 = 8'd0;
  logic       tx0, ready0, busy0, done0;
  logic       tx1, ready1, busy1, done1;

  uart_tx #(.CLKS_PER_BIT(16)) u_dut16 (
    .clk(clk), .reset(rst0), .tx_start(start0), .tx_data(data0),
    .tx(tx0), .tx_ready(ready0), .tx_busy(busy0), .tx_done(done0)
  );

  uart_tx #(.CLKS_PER_BIT(2)) u_dut2 (
    .clk(clk), .reset(rst1), .tx_start(start1), .tx_data(data1),
    .tx(tx1), .tx_ready(ready1), .tx_busy(busy1), .tx_done(done1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  function automatic int cpb(input int i);
    return (i == 0) ? 16 : 2;
  endfunction
  function automatic logic txv(input int i);  return (i == 0) ? tx0 : tx1;       endfunction
  function automatic logic rdy(input int i);  return (i == 0) ? ready0 : ready1; endfunction
  function automatic logic bsy(input int i);  return (i == 0) ? busy0 : busy1;   endfunction
  function automatic logic dn(input int i);   return (i == 0) ? done0 : done1;   endfunction

  task automatic drive(input int i, input logic s, input logic [7:0] d);
    if (i == 0) begin start0 = s; data0 = d; end
    else        begin start1 = s; data1 = d; end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------
  // Reference model: a frame is (byte, edge index of the falling edge).
  // Line value at any cycle is looked up from the position inside the frame.
  // ---------------------------------------------------------------------
  longint     kedge = 0;
  bit         m_valid [2];
  bit         m_active[2];
  longint     m_t0    [2];
  logic [7:0] m_byte  [2];
  bit         m_hv    [2];
  logic [7:0] m_hold  [2];
  logic       e_tx    [2];
  logic       e_ready [2];
  logic       e_busy  [2];
  logic       e_done  [2];

  function automatic logic frame_bit(input logic [7:0] b, input longint n);
    if (n == 0) return 1'b0;
    if (n <= 8) return b[n-1];
`ifdef UART_TX_PARITY_EN
    if (n == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic model_step(input int i, input longint e);
    logic       r, s, hv_old, done_now;
    logic [7:0] d;
    r = (i == 0) ? rst0 : rst1;
    s = (i == 0) ? start0 : start1;
    d = (i == 0) ? data0 : data1;
    if (r) begin
      m_active[i] = 0;
      m_hv[i]     = 0;
      m_valid[i]  = 1;
      done_now    = 0;
    end else begin
      hv_old   = m_hv[i];
      done_now = m_active[i] && (e - m_t0[i] == longint'(NB * cpb(i)));
      if (done_now) m_active[i] = 0;
      if (hv_old && !m_active[i]) begin
        m_active[i] = 1;
        m_t0[i]     = e;
        m_byte[i]   = m_hold[i];
        m_hv[i]     = 0;
      end else if (s && !hv_old) begin
        m_hv[i]   = 1;
        m_hold[i] = d;
      end
    end
    e_tx[i]    = m_active[i] ? frame_bit(m_byte[i], (e - m_t0[i]) / cpb(i)) : 1'b1;
    e_busy[i]  = m_active[i];
    e_ready[i] = !m_hv[i];
    e_done[i]  = done_now;
  endtask

  // Compare on the falling edge, then advance the model with the inputs the
  // next rising edge will see.
  initial begin
    forever begin
      @(negedge clk);
      kedge++;
      for (int i = 0; i < 2; i++) begin
        if (m_valid[i]) begin
          check($sformatf("model_tx%0d", i),    txv(i), e_tx[i]);
          check($sformatf("model_ready%0d", i), rdy(i), e_ready[i]);
          check($sformatf("model_busy%0d", i),  bsy(i), e_busy[i]);
          check($sformatf("model_done%0d", i),  dn(i),  e_done[i]);
        end
        model_step(i, kedge);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------

  // Accept a byte while idle and confirm tx falls exactly one cycle later.
  task automatic send(input int i, input logic [7:0] b);
    drive(i, 1'b1, b);
    tick();
    drive(i, 1'b0, 8'd0);
    check("accept_no_fall_yet", txv(i), 1'b1);
    tick();
    check("fall_latency", txv(i), 1'b0);
  endtask

  // Walk one frame starting at offset off0 from its falling edge. Samples
  // the first and middle cycle of each bit period and optionally offers
  // bytes at offsets ia / ib. Returns at offset NB*cpb.
  task automatic capture(input int i, input int off0,
                         input int ia, input logic [7:0] ba,
                         input int ib, input logic [7:0] bb,
                         output logic [NB-1:0] bits_m, output logic [NB-1:0] bits_f);
    int c;
    c = cpb(i);
    bits_m = '0;
    bits_f = '0;
    for (int o = off0; o < NB * c; o++) begin
      if (o == ia)      drive(i, 1'b1, ba);
      else if (o == ib) drive(i, 1'b1, bb);
      else              drive(i, 1'b0, 8'd0);
      if (ia >= 0 && o == ia + 1) check("queued_ready_low", rdy(i), 1'b0);
      if (o % c == 0)     bits_f[o / c] = txv(i);
      if (o % c == c / 2) bits_m[o / c] = txv(i);
      tick();
    end
    drive(i, 1'b0, 8'd0);
  endtask

  task automatic check_frame(input string name, input logic [NB-1:0] bits, input logic [7:0] b);
    check({name, "_start"}, bits[0], 1'b0);
    check({name, "_data"},  bits[8:1], b);
    check({name, "_stop"},  bits[NB-1], 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB-1:0] bm, bf;
    int zeros, dones;

    repeat (3) tick();
    rst0 = 1'b0;
    rst1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("reset_tx", txv(i), 1'b1);
      check("reset_ready", rdy(i), 1'b1);
      check("reset_busy", bsy(i), 1'b0);
      check("reset_done", dn(i), 1'b0);
    end
    tick();

    // 1: single frame 0xA5
    send(0, 8'hA5);
    capture(0, 0, -1, 8'd0, -1, 8'd0, bm, bf);
    check_frame("a5", bm, 8'hA5);
    check("a5_bits_literal", bm[8:1], 8'b1010_0101);
    check("a5_done_at_frame_end", done0, 1'b1);
    check("a5_busy_falls", busy0, 1'b0);
    check("a5_ready", ready0, 1'b1);
    tick();
    check("a5_done_one_cycle", done0, 1'b0);
    repeat (5) tick();

    // 2: back-to-back 0x00 then 0xFF
    send(0, 8'h00);
    capture(0, 0, 40, 8'hFF, -1, 8'd0, bm, bf);
    check_frame("b2b_first", bm, 8'h00);
    check("b2b_done1", done0, 1'b1);
    check("b2b_no_gap_tx", tx0, 1'b0);
    check("b2b_still_busy", busy0, 1'b1);
    check("b2b_ready_after_transfer", ready0, 1'b1);
    capture(0, 0, -1, 8'd0, -1, 8'd0, bm, bf);
    check_frame("b2b_second", bm, 8'hFF);
    check("b2b_done2_after_frame", done0, 1'b1);
    check("b2b_idle", busy0, 1'b0);
    repeat (5) tick();

    // 3: overflow drop of 0x3C while 0x96 is queued
    send(0, 8'h11);
    capture(0, 0, 30, 8'h96, 60, 8'h3C, bm, bf);
    check_frame("ovf_first", bm, 8'h11);
    check("ovf_chain", tx0, 1'b0);
    capture(0, 0, -1, 8'd0, -1, 8'd0, bm, bf);
    check_frame("ovf_queued", bm, 8'h96);
    check("ovf_idle_after", busy0, 1'b0);
    zeros = 0;
    for (int k = 0; k < FRAME16 + 20; k++) begin
      if (tx0 == 1'b0) zeros++;
      tick();
    end
    check("ovf_dropped_never_sent", zeros, 0);

    // 4: reset during data bit 3 of 0x55 with a byte queued
    send(0, 8'h55);
    for (int o = 0; o < 70; o++) begin
      drive(0, o == 20, 8'hE7);
      tick();
    end
    drive(0, 1'b0, 8'd0);
    check("rst_queued_before", ready0, 1'b0);
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    check("rst_tx", tx0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_ready", ready0, 1'b1);
    check("rst_done", done0, 1'b0);
    zeros = 0;
    dones = 0;
    for (int k = 0; k < FRAME16 + 20; k++) begin
      if (tx0 == 1'b0) zeros++;
      if (done0) dones++;
      tick();
    end
    check("rst_no_frame", zeros, 0);
    check("rst_no_done", dones, 0);

`ifdef UART_TX_PARITY_EN
    // 6: parity frames
    send(0, 8'h07);
    capture(0, 0, -1, 8'd0, -1, 8'd0, bm, bf);
    check_frame("par07", bm, 8'h07);
    check("par07_parity", bm[9], 1'b1);
    check("par07_done_176", done0, 1'b1);
    repeat (3) tick();
    send(0, 8'h03);
    capture(0, 0, -1, 8'd0, -1, 8'd0, bm, bf);
    check_frame("par03", bm, 8'h03);
    check("par03_parity", bm[9], 1'b0);
    check("par03_done_176", done0, 1'b1);
    repeat (3) tick();
`endif

    // 5: minimum bit time, 0x81
    send(1, 8'h81);
    capture(1, 0, -1, 8'd0, -1, 8'd0, bm, bf);
    check_frame("min_mid", bm, 8'h81);
    check_frame("min_first", bf, 8'h81);
    check("min_done_at_frame_end", done1, 1'b1);
    check("min_idle", busy1, 1'b0);
    repeat (3) tick();

    // Randomized traffic on both instances, occasional resets.
    fork
      begin
        repeat (3000) begin
          drive(0, $urandom_range(0, 3) == 0, 8'($urandom));
          rst0 = ($urandom_range(0, 999) == 0);
          tick();
        end
        drive(0, 1'b0, 8'd0);
        rst0 = 1'b0;
      end
      begin
        repeat (3000) begin
          drive(1, $urandom_range(0, 2) == 0, 8'($urandom));
          rst1 = ($urandom_range(0, 499) == 0);
          tick();
        end
        drive(1, 1'b0, 8'd0);
        rst1 = 1'b0;
      end
    join
    repeat (FRAME16 * 2 + 10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
